stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
Control FSM for the 4-digit BCD stopwatch counter chain of cascaded decade counters.
- Generates the least-significant digit's count enable from a sys_clk prescaler.
- Drives load, preset and direction to the chain.
- Handles start/stop, lap-freeze and clear commands.
- Detects countdown expiry.
- Sits between the button front end and the digit chain / display mux.

Parameters:
TICK_DIV, 100000, sys_clk cycles per LSD count (>=2)
TICK_W, 17, prescaler width; must hold TICK_DIV-1

Ports:
sys_clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
btn_start_stop  in  1  start/pause toggle command pulse
btn_lap  in  1  lap freeze/release toggle command pulse
btn_clear  in  1  clear/reload command pulse
cfg_countdown  in  1  1 = count down from preset, 0 = count up from zero
preset_value  in  16  4 BCD digits, countdown start value
digits_in  in  16  current BCD value of counter chain
tick_enb  out  1  count enable to LSD counter, 1-cycle pulse
cfg_cntr_mode  out  1  direction to chain: 1 up, 0 down
load_cnt  out  1  load strobe to all digits
load_value  out  16  BCD value loaded on load_cnt
display_digits  out  16  digits_in, or frozen lap value
lap_hold  out  1  display frozen
expired  out  1  countdown reached 0000
state  out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 DONE

Behaviour:
- Clock and reset: sys_clk, with asynchronous active-low reset_n. All outputs are registered except display_digits (combinational mux).
- Reset values: state=IDLE; prescaler=0; tick_enb=0; load_cnt=0; load_value=0; lap_hold=0; lap register=0; expired=0; cfg_cntr_mode=1; latched mode=up.
- Command priority, same cycle: clear > start_stop > lap.
- Clear, accepted in any state:
  - next cycle load_cnt=1 for exactly 1 cycle;
  - load_value = cfg_countdown ? preset_value : 16'h0000;
  - cfg_countdown latched; cfg_cntr_mode = ~latched;
  - prescaler=0, lap_hold=0, expired=0, state -> IDLE.
- cfg_countdown is sampled only at clear. Changes at other times are ignored.
- IDLE:
  - start_stop -> RUN, prescaler=0;
  - lap ignored; no tick.
- RUN:
  - prescaler increments each cycle.
  - When prescaler==TICK_DIV-1: it wraps to 0 and tick_enb=1 for the next cycle.
  - First tick therefore lands TICK_DIV cycles after entering RUN.
  - start_stop -> PAUSE; a tick due in that same cycle is suppressed.
- PAUSE:
  - prescaler holds its value; no ticks;
  - start_stop -> RUN, resuming from the held prescaler value;
  - lap still toggles.
- Countdown expiry:
  - Condition: latched mode=down, tick due, digits_in==16'h0000.
  - No tick is issued; state -> DONE; expired=1 (registered, same edge).
  - Prevents wrap 0000->9999.
- Up-count overflow: in up mode, 9999 wraps to 0000 in the chain; the controller keeps running (no special case).
- DONE:
  - no ticks; start_stop and lap ignored;
  - only clear exits (-> IDLE via load).
- Lap, in RUN/PAUSE:
  - lap_hold=0 -> capture digits_in into lap register, lap_hold=1;
  - lap_hold=1 -> lap_hold=0.
  - display_digits = lap_hold ? lap register : digits_in.
  - The counter chain keeps counting while frozen.
- Reset mid-operation: immediate return to reset values, no load pulse. A clear is required to establish the preset.
- tick_enb and load_cnt are never asserted in the same cycle.

Optional Feature:
STOPWATCH_BTN_SYNC_EN
- Defined:
  - each btn_* passes through a 2-flop synchronizer plus rising-edge detector;
  - a level held high yields one command;
  - command latency is +3 cycles.
- Undefined:
  - btn_* are synchronous single-cycle pulses, acted on at the next edge;
  - a held level re-triggers every cycle.

Test Plan:
- TICK_DIV=4, reset, clear with cfg_countdown=0 -> load_cnt=1 one cycle with load_value=0000, cfg_cntr_mode=1.
- Start -> tick_enb every 4th cycle, first tick 4 cycles after RUN entry. Stop after 6 cycles, hold 10 cycles, restart -> next tick after 2 more RUN cycles.
- cfg_countdown=1, preset 0002, clear, start, chain model decrementing -> ticks at 0002 and 0001. At 0000, next due tick absent, state=11, expired=1; further start ignored.
- RUN at digits 0123, lap -> display_digits stays 0123 while the chain advances. Lap again -> display follows digits_in.
- Clear and start_stop pulsed in the same cycle during RUN -> load_cnt pulse, state=IDLE, no tick.
- Reset asserted mid-RUN with lap_hold=1 -> all outputs return to reset values immediately. With the macro defined, a 5-cycle button level gives exactly one command, 3 cycles late.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Sequencing FSM for the 4-digit BCD stopwatch chain: prescaled tick, load/preset, lap freeze, countdown expiry.
// Optional STOPWATCH_BTN_SYNC_EN adds 2-flop synchronizers and rising-edge detection on btn_* inputs.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 100000,
  parameter int TICK_W   = 17
) (
  input  logic        sys_clk,
  input  logic        reset_n,
  input  logic        btn_start_stop,
  input  logic        btn_lap,
  input  logic        btn_clear,
  input  logic        cfg_countdown,
  input  logic [15:0] preset_value,
  input  logic [15:0] digits_in,
  output logic        tick_enb,
  output logic        cfg_cntr_mode,
  output logic        load_cnt,
  output logic [15:0] load_value,
  output logic [15:0] display_digits,
  output logic        lap_hold,
  output logic        expired,
  output logic [1:0]  state
);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_DONE  = 2'b11;

  logic cmd_ss, cmd_lap, cmd_clear;

`ifdef STOPWATCH_BTN_SYNC_EN
  // [0],[1] synchronize; [2] is the previous synchronized level for edge detection
  logic [2:0] sync_ss, sync_lap, sync_clr;
  logic       cmd_ss_q, cmd_lap_q, cmd_clr_q;

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_ss   <= '0;
      sync_lap  <= '0;
      sync_clr  <= '0;
      cmd_ss_q  <= 1'b0;
      cmd_lap_q <= 1'b0;
      cmd_clr_q <= 1'b0;
    end else begin
      sync_ss   <= {sync_ss[1:0], btn_start_stop};
      sync_lap  <= {sync_lap[1:0], btn_lap};
      sync_clr  <= {sync_clr[1:0], btn_clear};
      cmd_ss_q  <= sync_ss[1] & ~sync_ss[2];
      cmd_lap_q <= sync_lap[1] & ~sync_lap[2];
      cmd_clr_q <= sync_clr[1] & ~sync_clr[2];
    end
  end

  assign cmd_ss    = cmd_ss_q;
  assign cmd_lap   = cmd_lap_q;
  assign cmd_clear = cmd_clr_q;
`else
  assign cmd_ss    = btn_start_stop;
  assign cmd_lap   = btn_lap;
  assign cmd_clear = btn_clear;
`endif

  logic [1:0]        state_q, state_d;
  logic [TICK_W-1:0] presc_q, presc_d;
  logic              tick_q, tick_d;
  logic              load_q, load_d;
  logic [15:0]       load_val_q, load_val_d;
  logic              lap_hold_q, lap_hold_d;
  logic [15:0]       lap_q, lap_d;
  logic              expired_q, expired_d;
  logic              mode_down_q, mode_down_d;
  logic              tick_due;

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      presc_q     <= '0;
      tick_q      <= 1'b0;
      load_q      <= 1'b0;
      load_val_q  <= '0;
      lap_hold_q  <= 1'b0;
      lap_q       <= '0;
      expired_q   <= 1'b0;
      mode_down_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      tick_q      <= tick_d;
      load_q      <= load_d;
      load_val_q  <= load_val_d;
      lap_hold_q  <= lap_hold_d;
      lap_q       <= lap_d;
      expired_q   <= expired_d;
      mode_down_q <= mode_down_d;
    end
  end

  assign tick_due = (state_q == S_RUN) && (presc_q == TICK_W'(TICK_DIV - 1));

  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    tick_d      = 1'b0;
    load_d      = 1'b0;
    load_val_d  = load_val_q;
    lap_hold_d  = lap_hold_q;
    lap_d       = lap_q;
    expired_d   = expired_q;
    mode_down_d = mode_down_q;
    if (cmd_clear) begin
      load_d      = 1'b1;
      load_val_d  = cfg_countdown ? preset_value : 16'h0000;
      mode_down_d = cfg_countdown;
      presc_d     = '0;
      lap_hold_d  = 1'b0;
      expired_d   = 1'b0;
      state_d     = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_ss) begin
            state_d = S_RUN;
            presc_d = '0;
          end
        end
        S_RUN: begin
          presc_d = tick_due ? '0 : presc_q + TICK_W'(1);
          // expiry swallows the tick so the chain never wraps 0000 -> 9999
          if (cmd_ss) begin
            state_d = S_PAUSE;
          end else if (tick_due && mode_down_q && (digits_in == 16'h0000)) begin
            state_d   = S_DONE;
            expired_d = 1'b1;
          end else begin
            tick_d = tick_due;
          end
        end
        S_PAUSE: begin
          if (cmd_ss) state_d = S_RUN;
        end
        default: ;
      endcase
      if (cmd_lap && !cmd_ss && ((state_q == S_RUN) || (state_q == S_PAUSE))) begin
        lap_hold_d = ~lap_hold_q;
        if (!lap_hold_q) lap_d = digits_in;
      end
    end
  end

  always_comb begin
    display_digits = lap_hold_q ? lap_q : digits_in;
    state          = state_q;
  end

  assign tick_enb      = tick_q;
  assign load_cnt      = load_q;
  assign load_value    = load_val_q;
  assign lap_hold      = lap_hold_q;
  assign expired       = expired_q;
  assign cfg_cntr_mode = ~mode_down_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with a behavioural BCD digit chain and a queue-based scoreboard.
module tb_stopwatch_ctrl;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_DONE  = 2'b11;

  logic        sys_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        btn_start_stop = 1'b0;
  logic        btn_lap = 1'b0;
  logic        btn_clear = 1'b0;
  logic        cfg_countdown = 1'b0;
  logic [15:0] preset_value = 16'h0000;
  logic [15:0] digits_in;
  logic        tick_enb, cfg_cntr_mode, load_cnt, lap_hold, expired;
  logic [15:0] load_value, display_digits;
  logic [1:0]  state;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail = 0;
  int   k = 0;

  always #5 sys_clk = ~sys_clk;

  stopwatch_ctrl #(.TICK_DIV(4), .TICK_W(2)) dut (
    .sys_clk        (sys_clk),
    .reset_n        (reset_n),
    .btn_start_stop (btn_start_stop),
    .btn_lap        (btn_lap),
    .btn_clear      (btn_clear),
    .cfg_countdown  (cfg_countdown),
    .preset_value   (preset_value),
    .digits_in      (digits_in),
    .tick_enb       (tick_enb),
    .cfg_cntr_mode  (cfg_cntr_mode),
    .load_cnt       (load_cnt),
    .load_value     (load_value),
    .display_digits (display_digits),
    .lap_hold       (lap_hold),
    .expired        (expired),
    .state          (state)
  );

  function automatic logic [15:0] bcd_step(input logic [15:0] v, input logic up);
    logic [15:0] r;
    logic        carry;
    r = v;
    carry = 1'b1;
    for (int d = 0; d < 4; d++) begin
      if (carry) begin
        if (up) begin
          if (r[d*4 +: 4] == 4'd9) r[d*4 +: 4] = 4'd0;
          else begin r[d*4 +: 4] = r[d*4 +: 4] + 4'd1; carry = 1'b0; end
        end else begin
          if (r[d*4 +: 4] == 4'd0) r[d*4 +: 4] = 4'd9;
          else begin r[d*4 +: 4] = r[d*4 +: 4] - 4'd1; carry = 1'b0; end
        end
      end
    end
    return r;
  endfunction

  // counter chain driven by the controller outputs
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n)      digits_in <= 16'h0000;
    else if (load_cnt) digits_in <= load_value;
    else if (tick_enb) digits_in <= bcd_step(digits_in, cfg_cntr_mode);
  end

  task automatic push(input string tag, input logic [15:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [15:0] obs);
    exp_t e;
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty observed %h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val)
      else begin
        n_fail++;
        $error("FAIL %s observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] val);
    push(tag, val);
    pop_chk(obs);
  endtask

  task automatic cyc(input logic ss, input logic lp, input logic clr,
                     input logic e_tick, input logic e_load, input logic [1:0] e_state);
    @(negedge sys_clk);
    btn_start_stop = ss;
    btn_lap        = lp;
    btn_clear      = clr;
    push("tick_enb", {15'd0, e_tick});
    push("load_cnt", {15'd0, e_load});
    push("state", {14'd0, e_state});
    @(posedge sys_clk);
    #1;
    btn_start_stop = 1'b0;
    btn_lap        = 1'b0;
    btn_clear      = 1'b0;
    pop_chk({15'd0, tick_enb});
    pop_chk({15'd0, load_cnt});
    pop_chk({14'd0, state});
  endtask

  // plain RUN cycles; a tick is expected whenever k mod 4 equals phase
  task automatic run(input int n, input int phase);
    for (int i = 0; i < n; i++) begin
      k++;
      cyc(1'b0, 1'b0, 1'b0, ((k % 4) == phase), 1'b0, S_RUN);
    end
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_state"}, {14'd0, state}, 16'h0000);
    chk({pfx, "_tick"}, {15'd0, tick_enb}, 16'h0000);
    chk({pfx, "_load"}, {15'd0, load_cnt}, 16'h0000);
    chk({pfx, "_load_value"}, load_value, 16'h0000);
    chk({pfx, "_lap_hold"}, {15'd0, lap_hold}, 16'h0000);
    chk({pfx, "_expired"}, {15'd0, expired}, 16'h0000);
    chk({pfx, "_cntr_mode"}, {15'd0, cfg_cntr_mode}, 16'h0001);
    chk({pfx, "_display"}, display_digits, 16'h0000);
  endtask

  initial begin
    #12;
    chk_reset_vals("rst");
    @(negedge sys_clk);
    reset_n = 1'b1;

    // clear in up mode
    cfg_countdown = 1'b0;
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, S_IDLE);
    chk("clr_up_load_value", load_value, 16'h0000);
    chk("clr_up_cntr_mode", {15'd0, cfg_cntr_mode}, 16'h0001);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE);

    // start, tick spacing, pause mid-period, resume from held prescaler
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_RUN);
    k = 0;
    run(5, 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_PAUSE);
    repeat (10) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_PAUSE);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_RUN);
    k = 0;
    run(9, 2);
    // stop on the cycle a tick is due: tick suppressed
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_PAUSE);
    chk("pause_display", display_digits, 16'h0003);

    // countdown from 0002 to expiry
    cfg_countdown = 1'b1;
    preset_value  = 16'h0002;
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, S_IDLE);
    chk("clr_dn_load_value", load_value, 16'h0002);
    chk("clr_dn_cntr_mode", {15'd0, cfg_cntr_mode}, 16'h0000);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_RUN);
    k = 0;
    run(11, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_DONE);
    chk("expired_set", {15'd0, expired}, 16'h0001);
    chk("expired_digits", display_digits, 16'h0000);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_DONE);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, S_DONE);
    chk("done_lap_ignored", {15'd0, lap_hold}, 16'h0000);
    chk("done_expired_hold", {15'd0, expired}, 16'h0001);

    // up count to 0123, lap freeze and release
    cfg_countdown = 1'b0;
    preset_value  = 16'h0000;
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, S_IDLE);
    chk("clr2_expired", {15'd0, expired}, 16'h0000);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_RUN);
    k = 0;
    run(493, 0);
    k++;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, S_RUN);
    chk("lap_hold_set", {15'd0, lap_hold}, 16'h0001);
    chk("lap_display", display_digits, 16'h0123);
    run(3, 0);
    chk("lap_frozen", display_digits, 16'h0123);
    chk("lap_chain_moves", digits_in, 16'h0124);
    k++;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, S_RUN);
    chk("lap_release", {15'd0, lap_hold}, 16'h0000);
    chk("lap_follow", display_digits, 16'h0124);

    // clear and start_stop together on a due-tick cycle
    run(1, 0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, S_IDLE);
    chk("clr_ss_load_value", load_value, 16'h0000);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE);

    // asynchronous reset mid-RUN with lap frozen
    cfg_countdown = 1'b1;
    preset_value  = 16'h0123;
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, S_IDLE);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_RUN);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_RUN);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, S_RUN);
    chk("pre_rst_lap", {15'd0, lap_hold}, 16'h0001);
    chk("pre_rst_display", display_digits, 16'h0123);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    @(negedge sys_clk);
    reset_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
